// File: rtl/mbldcm_phase_stepper.sv
// Commutation phase sequencer: steps the phase index every iDiv cycles while running.
// Optional reverse stepping is enabled by defining MBLDCM_PHASESTEP_DIR_EN.
module mbldcm_phase_stepper #(
    parameter logic [3:0] pTotalPhaseStages = 4'd12,
    parameter int         pWidthStepCount   = 16
) (
    input  logic                       iClock,
    input  logic                       iReset_n,
    input  logic [31:0]                iDiv,
    input  logic                       iStop,
`ifdef MBLDCM_PHASESTEP_DIR_EN
    input  logic                       iDir,
`endif
    output logic [3:0]                 oPhase,
    output logic                       oStep,
    output logic                       oRevolution,
    output logic                       oRunning,
    output logic [pWidthStepCount-1:0] oStepCount
);

    // No handshake here: iDiv and iStop are level signals sampled on every rising edge of iClock.
    typedef enum logic {
        sIdle = 1'b0,
        sRun  = 1'b1
    } tState;

    localparam logic [3:0] cLastPhase = pTotalPhaseStages - 4'd1;

    tState                      rState;
    tState                      wStateNext;
    logic [31:0]                rCnt;
    logic [31:0]                wCntNext;
    logic [31:0]                rDivL;
    logic [31:0]                wDivLNext;
    logic [3:0]                 rPhase;
    logic [3:0]                 wPhaseNext;
    logic                       rStep;
    logic                       wStepNext;
    logic                       rRev;
    logic                       wRevNext;
    logic [pWidthStepCount-1:0] rStepCount;
    logic [pWidthStepCount-1:0] wStepCountNext;
    logic [31:0]                wDivSat;
    logic                       wStepEdge;
    logic                       wDir;

`ifdef MBLDCM_PHASESTEP_DIR_EN
    assign wDir = iDir;
`else
    assign wDir = 1'b0;
`endif

    assign wDivSat   = (iDiv == 32'd0) ? 32'd1 : iDiv;
    assign wStepEdge = (rState == sRun) && !iStop && (rCnt == rDivL - 32'd1);

    // State register together with the datapath registers it controls.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            rState     <= sIdle;
            rCnt       <= 32'd0;
            rDivL      <= 32'd1;
            rPhase     <= 4'd0;
            rStep      <= 1'b0;
            rRev       <= 1'b0;
            rStepCount <= '0;
        end else begin
            rState     <= wStateNext;
            rCnt       <= wCntNext;
            rDivL      <= wDivLNext;
            rPhase     <= wPhaseNext;
            rStep      <= wStepNext;
            rRev       <= wRevNext;
            rStepCount <= wStepCountNext;
        end
    end

    always_comb begin
        wStateNext = rState;
        case (rState)
            sIdle: if (!iStop) wStateNext = sRun;
            sRun:  if (iStop)  wStateNext = sIdle;
        endcase
    end

    // Stop takes priority over a coinciding step edge, so the phase simply holds.
    always_comb begin
        wCntNext       = rCnt;
        wDivLNext      = rDivL;
        wPhaseNext     = rPhase;
        wStepNext      = 1'b0;
        wRevNext       = 1'b0;
        wStepCountNext = rStepCount;
        case (rState)
            sIdle: begin
                wCntNext = 32'd0;
                if (!iStop) wDivLNext = wDivSat;
            end
            sRun: begin
                if (iStop) begin
                    wCntNext = 32'd0;
                end else if (wStepEdge) begin
                    wCntNext       = 32'd0;
                    wDivLNext      = wDivSat;
                    wStepNext      = 1'b1;
                    wStepCountNext = rStepCount + pWidthStepCount'(1);
                    if (!wDir) begin
                        if (rPhase >= cLastPhase) begin
                            wPhaseNext = 4'd0;
                            wRevNext   = 1'b1;
                        end else begin
                            wPhaseNext = rPhase + 4'd1;
                        end
                    end else begin
                        if (rPhase == 4'd0) begin
                            wPhaseNext = cLastPhase;
                            wRevNext   = 1'b1;
                        end else begin
                            wPhaseNext = rPhase - 4'd1;
                        end
                    end
                end else begin
                    wCntNext = rCnt + 32'd1;
                end
            end
        endcase
    end

    assign oPhase      = rPhase;
    assign oStep       = rStep;
    assign oRevolution = rRev;
    assign oRunning    = (rState == sRun);
    assign oStepCount  = rStepCount;

endmodule

// File: tb/tb_mbldcm_phase_stepper.sv
// Self-checking bench for mbldcm_phase_stepper: directed scenarios plus random traffic,
// compared every cycle against an event-time model of the stepper.
module tb_mbldcm_phase_stepper;

    localparam int cN = 12;
    localparam int cW = 16;
`ifdef MBLDCM_PHASESTEP_DIR_EN
    localparam bit cDirEn = 1'b1;
`else
    localparam bit cDirEn = 1'b0;
`endif

    logic          iClock = 1'b0;
    logic          iReset_n;
    logic [31:0]   iDiv;
    logic          iStop;
    logic          iDir;
    logic [3:0]    oPhase;
    logic          oStep;
    logic          oRevolution;
    logic          oRunning;
    logic [cW-1:0] oStepCount;

    always #5 iClock = ~iClock;

    mbldcm_phase_stepper #(
        .pTotalPhaseStages(4'd12),
        .pWidthStepCount  (cW)
    ) dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iDiv       (iDiv),
        .iStop      (iStop),
`ifdef MBLDCM_PHASESTEP_DIR_EN
        .iDir       (iDir),
`endif
        .oPhase     (oPhase),
        .oStep      (oStep),
        .oRevolution(oRevolution),
        .oRunning   (oRunning),
        .oStepCount (oStepCount)
    );

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // Model: absolute cycle of the next scheduled step instead of a cycle counter.
    bit          mRun   = 1'b0;
    int          mPhase = 0;
    int unsigned mCount = 0;
    bit          mStep  = 1'b0;
    bit          mRev   = 1'b0;
    longint      mNext  = 0;

    function automatic longint effDiv(input logic [31:0] d);
        return (d == 32'd0) ? 64'd1 : longint'(d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        bit rev;
        rev   = cDirEn && iDir;
        mStep = 1'b0;
        mRev  = 1'b0;
        if (!iReset_n) begin
            mRun   = 1'b0;
            mPhase = 0;
            mCount = 0;
        end else if (!mRun) begin
            if (!iStop) begin
                mRun  = 1'b1;
                mNext = cyc + effDiv(iDiv);
            end
        end else if (iStop) begin
            mRun = 1'b0;
        end else if (cyc == mNext) begin
            mStep  = 1'b1;
            mRev   = rev ? (mPhase == 0) : (mPhase == cN - 1);
            mPhase = rev ? (mPhase + cN - 1) % cN : (mPhase + 1) % cN;
            mCount = (mCount + 1) % (1 << cW);
            mNext  = cyc + effDiv(iDiv);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        cyc++;
        modelEdge();
        #1;
        check("phase", 64'(oPhase), mPhase);
        check("step", 64'(oStep), mStep);
        check("revolution", 64'(oRevolution), mRev);
        check("running", 64'(oRunning), mRun);
        check("stepCount", 64'(oStepCount), mCount);
    endtask

    // Advance until oStep is seen; n returns the number of ticks taken.
    task automatic waitStep(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!oStep && n < 100);
        check({tag, "_timeout"}, 64'(n < 100), 1);
    endtask

    initial begin
        int     n;
        int     steps;
        int     revs;
        longint runCyc;
        longint stepCyc;
        int     prevPhase;

        iReset_n = 1'b0;
        iStop    = 1'b1;
        iDiv     = 32'd5;
        iDir     = 1'b0;
        repeat (3) tick();
        check("reset_phase", 64'(oPhase), 0);
        check("reset_running", 64'(oRunning), 0);

        // Start with iDiv=5 and run one full revolution.
        iReset_n = 1'b1;
        iStop    = 1'b0;
        tick();
        check("start_running", 64'(oRunning), 1);
        runCyc  = cyc;
        stepCyc = 0;
        steps   = 0;
        revs    = 0;
        for (int i = 0; i < 5 * cN; i++) begin
            tick();
            if (oStep) begin
                steps++;
                if (steps == 1) stepCyc = cyc;
            end
            if (oRevolution) revs++;
        end
        check("first_step_latency", 64'(stepCyc - runCyc), 5);
        check("rev_steps", 64'(steps), 12);
        check("rev_count", 64'(revs), 1);
        check("rev_stepcount", 64'(oStepCount), 12);
        check("rev_phase", 64'(oPhase), 0);

        // Divider change inside a period applies only from the next step.
        tick();
        iDiv = 32'd3;
        waitStep("div_change_a", n);
        check("div_change_old_period", 64'(n + 1), 5);
        waitStep("div_change_b", n);
        check("div_change_new_period", 64'(n), 3);

        // iDiv=0 and iDiv=1 both step every cycle.
        iDiv = 32'd0;
        waitStep("div0_sync", n);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) iDiv = 32'd1;
            for (int i = 0; i < 6; i++) begin
                prevPhase = oPhase;
                tick();
                check("continuous_step", 64'(oStep), 1);
                check("continuous_phase", 64'(oPhase), (prevPhase + 1) % cN);
            end
        end

        // Stop exactly on a step edge at phase 7.
        iDiv = 32'd3;
        n = 0;
        while (!(mRun && mPhase == 7 && mNext == cyc + 1) && n < 200) begin
            tick();
            n++;
        end
        check("stop_edge_reach", 64'(n < 200), 1);
        iStop = 1'b1;
        tick();
        check("stop_edge_phase", 64'(oPhase), 7);
        check("stop_edge_running", 64'(oRunning), 0);
        check("stop_edge_nostep", 64'(oStep), 0);
        iStop = 1'b0;
        iDiv  = 32'd4;
        tick();
        waitStep("restart", n);
        check("restart_latency", 64'(n), 4);
        check("restart_phase", 64'(oPhase), 8);

        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) iDiv = 32'($urandom_range(0, 6));
            iStop = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) iDir = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset in the middle of a step period at phase 6.
        iStop = 1'b0;
        iDir  = 1'b0;
        iDiv  = 32'd4;
        n = 0;
        while (!(mRun && mPhase == 6 && mNext > cyc + 2) && n < 500) begin
            tick();
            n++;
        end
        check("reset_mid_reach", 64'(n < 500), 1);
        iReset_n = 1'b0;
        iDiv     = 32'd2;
        tick();
        check("reset_mid_phase", 64'(oPhase), 0);
        check("reset_mid_count", 64'(oStepCount), 0);
        check("reset_mid_running", 64'(oRunning), 0);
        check("reset_mid_step", 64'(oStep), 0);
        iReset_n = 1'b1;
        tick();
        waitStep("reset_restart", n);
        check("reset_restart_latency", 64'(n), 2);
        check("reset_restart_phase", 64'(oPhase), 1);

`ifdef MBLDCM_PHASESTEP_DIR_EN
        // Reverse from phase 1: 0, then 11 with a wrap, then 10.
        iDir = 1'b1;
        waitStep("rev_a", n);
        check("rev_phase_a", 64'(oPhase), 0);
        waitStep("rev_b", n);
        check("rev_phase_b", 64'(oPhase), 11);
        check("rev_wrap_b", 64'(oRevolution), 1);
        waitStep("rev_c", n);
        check("rev_phase_c", 64'(oPhase), 10);
        check("rev_count_c", 64'(oStepCount), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
